// File: rtl/posit_shift_arbiter.sv
// Two-port round-robin front end for one shared right shifter with sticky.
// Shift amounts past N-1 take a second pass; sticky accumulates across passes.
module right_shifter_sticky_18 #(
   parameter int W  = 15,
   parameter int SW = 4
) (
   input  logic [W-1:0]  i_data,
   input  logic [SW-1:0] i_shamt,
   input  logic          i_pad,
   output logic [W-1:0]  o_data,
   output logic          o_sticky
);
   logic [2*W-1:0] wide;
   logic [W-1:0]   lost_mask;

   always_comb begin
      wide      = {{W{i_pad}}, i_data} >> i_shamt;
      o_data    = wide[W-1:0];
      lost_mask = ~({W{1'b1}} << i_shamt);
      o_sticky  = |(i_data & lost_mask);
   end
endmodule

module posit_shift_arbiter #(
   parameter int N = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_req0_valid,
   input  logic                   i_req1_valid,
   output logic                   o_req0_ready,
   output logic                   o_req1_ready,
   input  logic [N-2:0]           i_req0_data,
   input  logic [N-2:0]           i_req1_data,
   input  logic [$clog2(N):0]     i_req0_shamt,
   input  logic [$clog2(N):0]     i_req1_shamt,
   input  logic                   i_req0_pad,
   input  logic                   i_req1_pad,
   output logic                   o_res_valid,
   input  logic                   i_res_ready,
   output logic [N-2:0]           o_res_data,
   output logic                   o_res_sticky,
   output logic                   o_res_id
);
   localparam int SW = $clog2(N);
   localparam int W  = N - 1;
   localparam logic [SW:0] SHAMT_TOP = (SW+1)'(2*N-1);
   localparam logic [SW:0] SHAMT_SAT = (SW+1)'(2*N-2);
   localparam logic [SW:0] PASS_MAX  = (SW+1)'(W);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t        state, state_nxt;
   logic [W-1:0]  work;
   logic [SW:0]   rem, rem_nxt;
   logic          pad, sticky, id, last_gnt;
   logic          gnt0, gnt1, accept;
   logic [SW-1:0] amt;
   logic [W-1:0]  sh_data;
   logic          sh_sticky;
   logic [SW:0]   shamt_sel;

   // Tie goes to the port not granted last; last_gnt resets to 1 so port 0 wins first.
   assign gnt0   = i_req0_valid & (~i_req1_valid | last_gnt);
   assign gnt1   = i_req1_valid & (~i_req0_valid | ~last_gnt);
   assign accept = (state == IDLE) & (gnt0 | gnt1);

   assign shamt_sel = gnt1 ? i_req1_shamt : i_req0_shamt;
   assign amt       = (rem > PASS_MAX) ? SW'(W) : rem[SW-1:0];
   assign rem_nxt   = rem - {1'b0, amt};

   right_shifter_sticky_18 #(.W(W), .SW(SW)) u_shifter (
      .i_data   (work),
      .i_shamt  (amt),
      .i_pad    (pad),
      .o_data   (sh_data),
      .o_sticky (sh_sticky)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SHIFT;
         SHIFT:   if (rem_nxt == '0) state_nxt = DONE;
         DONE:    if (i_res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_req0_ready = (state == IDLE) & gnt0;
      o_req1_ready = (state == IDLE) & gnt1;
      o_res_valid  = (state == DONE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         work     <= '0;
         rem      <= '0;
         pad      <= 1'b0;
         sticky   <= 1'b0;
         id       <= 1'b0;
         last_gnt <= 1'b1;
      end else if (accept) begin
         work     <= gnt1 ? i_req1_data : i_req0_data;
         rem      <= (shamt_sel == SHAMT_TOP) ? SHAMT_SAT : shamt_sel;
         pad      <= gnt1 ? i_req1_pad : i_req0_pad;
         sticky   <= 1'b0;
         id       <= gnt1;
         last_gnt <= gnt1;
      end else if (state == SHIFT) begin
         work   <= sh_data;
         sticky <= sticky | sh_sticky;
         rem    <= rem_nxt;
      end
   end

   assign o_res_data   = work;
   assign o_res_sticky = sticky;
   assign o_res_id     = id;
endmodule

// File: tb/tb_posit_shift_arbiter.sv
// Randomized bench for posit_shift_arbiter against an arithmetic reference model.
module tb_posit_shift_arbiter;
   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_req0_valid, i_req1_valid;
   logic        o_req0_ready, o_req1_ready;
   logic [14:0] i_req0_data, i_req1_data;
   logic [4:0]  i_req0_shamt, i_req1_shamt;
   logic        i_req0_pad, i_req1_pad;
   logic        o_res_valid;
   logic        i_res_ready;
   logic [14:0] o_res_data;
   logic        o_res_sticky;
   logic        o_res_id;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned last_gnt;

   posit_shift_arbiter #(.N(16)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_req0_valid (i_req0_valid),
      .i_req1_valid (i_req1_valid),
      .o_req0_ready (o_req0_ready),
      .o_req1_ready (o_req1_ready),
      .i_req0_data  (i_req0_data),
      .i_req1_data  (i_req1_data),
      .i_req0_shamt (i_req0_shamt),
      .i_req1_shamt (i_req1_shamt),
      .i_req0_pad   (i_req0_pad),
      .i_req1_pad   (i_req1_pad),
      .o_res_valid  (o_res_valid),
      .i_res_ready  (i_res_ready),
      .o_res_data   (o_res_data),
      .o_res_sticky (o_res_sticky),
      .o_res_id     (o_res_id)
   );

   always #5 i_clk = ~i_clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic scramble_inputs();
      i_req0_valid = 1'($urandom);
      i_req1_valid = 1'($urandom);
      i_req0_data  = 15'($urandom);
      i_req1_data  = 15'($urandom);
      i_req0_shamt = 5'($urandom);
      i_req1_shamt = 5'($urandom);
      i_req0_pad   = 1'($urandom);
      i_req1_pad   = 1'($urandom);
   endtask

   // Called and returns at a negedge with the DUT idle.
   task automatic do_op(input logic [1:0] vm, input logic [14:0] d0, input logic [14:0] d1,
                        input logic [4:0] s0, input logic [4:0] s1,
                        input logic p0, input logic p1, input int unsigned stall);
      int unsigned g, s, passes, lat;
      logic [14:0] ed, dsel;
      logic        es, psel;
      logic [63:0] ext;
      g    = (vm == 2'b11) ? (1 - last_gnt) : (vm[1] ? 1 : 0);
      dsel = (g == 1) ? d1 : d0;
      psel = (g == 1) ? p1 : p0;
      s    = (g == 1) ? int'(s1) : int'(s0);
      if (s == 31) s = 30;
      // Operand conceptually extended with infinitely many pad bits above it.
      ext    = {49'b0, dsel} | (psel ? ~64'h7FFF : 64'h0);
      ed     = 15'(ext >> s);
      es     = (ext & ((64'd1 << s) - 64'd1)) != 64'd0;
      passes = (s > 15) ? 2 : 1;

      i_req0_valid = vm[0]; i_req1_valid = vm[1];
      i_req0_data = d0; i_req1_data = d1;
      i_req0_shamt = s0; i_req1_shamt = s1;
      i_req0_pad = p0; i_req1_pad = p1;
      #1;
      check_eq("ready0", 32'(o_req0_ready), 32'(g == 0));
      check_eq("ready1", 32'(o_req1_ready), 32'(g == 1));
      @(posedge i_clk);
      last_gnt = g;
      #1 scramble_inputs();
      @(negedge i_clk);
      lat = 0;
      while (!o_res_valid && lat < 8) begin
         check_eq("busy_rdy", 32'({o_req1_ready, o_req0_ready}), 32'd0);
         @(posedge i_clk);
         #1 scramble_inputs();
         @(negedge i_clk);
         lat++;
      end
      check_eq("latency", lat, passes);
      check_eq("done_rdy", 32'({o_req1_ready, o_req0_ready}), 32'd0);
      i_req0_valid = 1'b0; i_req1_valid = 1'b0;
      check_eq("data", 32'(o_res_data), 32'(ed));
      check_eq("sticky", 32'(o_res_sticky), 32'(es));
      check_eq("id", 32'(o_res_id), g);
      for (int unsigned i = 0; i < stall; i++) begin
         @(posedge i_clk);
         @(negedge i_clk);
         check_eq("stall_valid", 32'(o_res_valid), 32'd1);
         check_eq("stall_data", 32'({o_res_id, o_res_sticky, o_res_data}),
                  32'({g[0], es, ed}));
      end
      i_res_ready = 1'b1;
      @(posedge i_clk);
      #1 i_res_ready = 1'b0;
      @(negedge i_clk);
      check_eq("drained", 32'(o_res_valid), 32'd0);
   endtask

   initial begin
      logic [14:0] d0, d1;
      logic [4:0]  s0, s1;
      logic [1:0]  vm;
      int unsigned quiet;
      i_rst_n = 1'b0;
      i_res_ready = 1'b0;
      i_req0_valid = 1'b0; i_req1_valid = 1'b0;
      i_req0_data = '0; i_req1_data = '0;
      i_req0_shamt = '0; i_req1_shamt = '0;
      i_req0_pad = 1'b0; i_req1_pad = 1'b0;
      last_gnt = 1;
      repeat (2) @(negedge i_clk);
      check_eq("rst_out", 32'({o_res_valid, o_res_sticky, o_res_id, o_res_data}), 32'd0);
      check_eq("rst_rdy", 32'({o_req1_ready, o_req0_ready}), 32'd0);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      // Fairness under backpressure: both ports always valid.
      for (int i = 0; i < 4; i++) begin
         check_eq("rr_order", 32'(1 - last_gnt), 32'(i % 2));
         do_op(2'b11, 15'($urandom), 15'($urandom), 5'($urandom), 5'($urandom),
               1'($urandom), 1'($urandom), 3);
      end

      do_op(2'b01, 15'h4001, 15'h0, 5'd3,  5'd0, 1'b0, 1'b0, 0);
      do_op(2'b10, 15'h0,    15'h7FF0, 5'd0, 5'd4, 1'b0, 1'b1, 1);
      do_op(2'b01, 15'h0001, 15'h0, 5'd20, 5'd0, 1'b0, 1'b0, 0);
      do_op(2'b01, 15'h0000, 15'h0, 5'd20, 5'd0, 1'b1, 1'b0, 0);
      do_op(2'b01, 15'h4000, 15'h0, 5'd31, 5'd0, 1'b0, 1'b0, 0);
      do_op(2'b10, 15'h0,    15'h1234, 5'd0, 5'd0, 1'b0, 1'b1, 0);
      do_op(2'b01, 15'h7FFF, 15'h0, 5'd15, 5'd0, 1'b1, 1'b0, 0);
      do_op(2'b10, 15'h0,    15'h5555, 5'd0, 5'd16, 1'b0, 1'b1, 2);

      // Reset during a two-pass shift.
      i_req0_valid = 1'b1; i_req0_data = 15'h7FFF; i_req0_shamt = 5'd25; i_req0_pad = 1'b1;
      @(posedge i_clk);
      #1 i_req0_valid = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b0;
      #1;
      check_eq("midrst_out", 32'({o_res_valid, o_res_sticky, o_res_data}), 32'd0);
      last_gnt = 1;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      quiet = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge i_clk);
         if (o_res_valid) quiet++;
      end
      check_eq("midrst_quiet", quiet, 32'd0);
      do_op(2'b11, 15'h0F0F, 15'h00FF, 5'd2, 5'd3, 1'b0, 1'b1, 0);

      for (int i = 0; i < 150; i++) begin
         vm = 2'($urandom_range(1, 3));
         d0 = 15'($urandom); d1 = 15'($urandom);
         s0 = 5'($urandom);  s1 = 5'($urandom);
         do_op(vm, d0, d1, s0, s1, 1'($urandom), 1'($urandom), $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/posit_shift_arbiter.md
# posit_shift_arbiter

Shares one `right_shifter_sticky_18` instance between two requesters: the posit adder's exponent-alignment stage (port 0) and the posit decoder's regime-strip stage (port 1). The block does three things:
- arbitrates round-robin between the two ports;
- extends the shift range beyond N-1 by issuing a second pass through the shifter, ORing the sticky bits of both passes;
- returns a tagged, registered result over a valid/ready handshake.

One operation is in flight at a time.

## Interface
Parameters:
- `N`, 16: posit width. The datapath is N-1 bits; the shifter amount is `SW = $clog2(N)` bits.

Ports:
- `i_clk`  in  1  clock; all state updates on its rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_req0_valid` / `i_req1_valid`  in  1  request present.
- `o_req0_ready` / `o_req1_ready`  out  1  request accepted this cycle when high together with the matching valid.
- `i_req0_data` / `i_req1_data`  in  N-1  operand.
- `i_req0_shamt` / `i_req1_shamt`  in  SW+1  requested right-shift amount, 0..2N-1.
- `i_req0_pad` / `i_req1_pad`  in  1  bit shifted in at the MSB.
- `o_res_valid`  out  1  result present.
- `i_res_ready`  in  1  consumer accepts the result.
- `o_res_data`  out  N-1  shifted operand.
- `o_res_sticky`  out  1  OR of every bit shifted out of the LSB, across all passes.
- `o_res_id`  out  1  port that issued the operation.

## Operation
- States: IDLE, SHIFT, DONE. Reset forces IDLE.
- **Arbitration (IDLE only):**
  - Grant goes to the only valid port.
  - If both ports are valid, grant goes to the port not granted last.
  - The last-grant pointer resets so that port 0 wins the first tie.
  - `o_reqX_ready = (state==IDLE) & grantX`. It is combinational and never high for both ports.
  - Outside IDLE both readies are 0.
- **Accept (valid & ready at an edge):**
  - Load the work register from data; load `rem` from shamt; load pad and id.
  - Saturate: shamt of 2N-1 is loaded as 2N-2 (= 30 for N=16).
  - Clear the sticky register.
  - Go to SHIFT.
- **SHIFT, each cycle:**
  - Shifter input is the work register. Amount is `min(rem, N-1)`.
  - At the edge: work ← shifter result; sticky ← sticky | shifter sticky; rem ← rem − amount.
  - If the new rem is 0, go to DONE; otherwise stay in SHIFT.
  - Shamt ≤ N-1 takes exactly one pass, including shamt 0, which yields sticky 0. Larger shamt takes exactly two passes.
- **Pad bits in the second pass:** pad bits shifted in during pass 1 and shifted out in pass 2 count toward sticky. Sticky means any bit lost, pad included.
- **DONE:**
  - `o_res_valid` = 1. `o_res_data`, `o_res_sticky` and `o_res_id` are driven from registers and stay stable while `i_res_ready` is 0.
  - Result handshake moves to IDLE.
- **Reset mid-operation:**
  - The pending operation is dropped with no result emitted.
  - All registers clear.
  - The last-grant pointer returns to its reset value.
- **Input stability:** requester inputs are sampled only at the accept edge. Later changes to them have no effect.

## Timing
- Reset values: `o_res_valid` 0, `o_res_data` 0, `o_res_sticky` 0, `o_res_id` 0. `o_req0_ready` / `o_req1_ready` are 0 unless the matching valid is high, because state is IDLE.
- Accept at edge k:
  - single pass: `o_res_valid` high after edge k+1;
  - two passes: high after edge k+2.
- Result handshake at edge m returns the block to IDLE. The earliest next accept is edge m+1, so peak throughput is one operation per 3 cycles for single-pass operations.
- Backpressure: `o_res_valid` stays high indefinitely until `i_res_ready`. No result is ever dropped or overwritten.
- There is no combinational path from `i_res_ready` to any output. The ready outputs depend combinationally only on state, the pointer and the valids.

## Test plan
- **Single pass, pad 0:**
  - Stimulus: port 0, data 15'h4001, shamt 3, pad 0, accepted at edge k.
  - Required: `o_res_valid` after edge k+1, data 15'h0800, sticky 1, id 0.
- **Single pass, pad 1:**
  - Stimulus: port 1, data 15'h7FF0, shamt 4, pad 1.
  - Required: data 15'h7FFF, sticky 0, id 1.
- **Two passes:**
  - Stimulus: port 0, data 15'h0001, shamt 20, pad 0, accepted at edge k.
  - Required: `o_res_valid` after edge k+2, data 0, sticky 1.
  - Repeat with data 15'h0000, shamt 20, pad 1. Required: data 15'h7FFF, sticky 1 (pad bits lost).
- **Saturation:**
  - Stimulus: shamt 31, data 15'h4000, pad 0.
  - Required: two passes, data 0, sticky 1.
  - Also shamt 0, data 15'h1234. Required: data 15'h1234, sticky 0, one pass.
- **Fairness and backpressure:**
  - Stimulus: both valids held high for 4 operations, with `i_res_ready` low for 3 cycles on each result.
  - Required: grant order 0,1,0,1. Result fields stable while stalled. Both readies 0 outside IDLE.
- **Reset mid-operation:**
  - Stimulus: assert `i_rst_n` low during a two-pass SHIFT.
  - Required: immediately `o_res_valid` 0, data 0, sticky 0. No result is emitted after release. The first tie after reset is granted to port 0.
